// File: rtl/stdp_synapse.sv
// Pair-based STDP synapse: nearest-neighbour pairing of pre/post spike edges with a
// shift-approximated exponential decay of the saturating weight update.

// Per-side spike trace: edge detector, distance timer and pairing-eligibility bit.
module stdp_trace #(
  parameter int unsigned TW     = 8,
  parameter int unsigned WINDOW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spike,
  input  logic          consume,
  output logic          edge_c,
  output logic [TW-1:0] timer,
  output logic          valid
);

  localparam logic [TW-1:0] WIN = TW'(WINDOW);

  logic          spike_q;
  logic [TW-1:0] timer_d;
  logic          valid_d;

  assign edge_c = spike & ~spike_q;

  // Own edge restarts the trace; a pairing consumes it; otherwise it ages out at WINDOW.
  always_comb begin
    timer_d = timer;
    valid_d = valid;
    if (edge_c) begin
      timer_d = TW'(1);
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end else if (valid) begin
      if (timer >= WIN) begin
        valid_d = 1'b0;
      end else begin
        timer_d = timer + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= 1'b0;
      timer   <= '0;
      valid   <= 1'b0;
    end else begin
      spike_q <= spike;
      timer   <= timer_d;
      valid   <= valid_d;
    end
  end

endmodule

module stdp_synapse #(
  parameter int unsigned W_INIT    = 128,
  parameter int unsigned W_MAX     = 255,
  parameter int unsigned A_PLUS    = 16,
  parameter int unsigned A_MINUS   = 12,
  parameter int unsigned WINDOW    = 32,
  parameter int unsigned TAU_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pre_spike,
  input  logic       post_spike,
  input  logic       learn_en,
  output logic [7:0] weight,
  output logic [7:0] time_diff,
  output logic       update_w_flag,
  output logic       ltp,
  output logic       ltd
);

  localparam int unsigned WW = 8;
  localparam int unsigned TW = 8;

  localparam logic [WW-1:0] W_INIT_V  = WW'(W_INIT);
  localparam logic [WW-1:0] W_MAX_V   = WW'(W_MAX);
  localparam logic [WW:0]   W_MAX_V9  = (WW+1)'(W_MAX);
  localparam logic [WW-1:0] A_PLUS_V  = WW'(A_PLUS);
  localparam logic [WW-1:0] A_MINUS_V = WW'(A_MINUS);

  logic          pre_edge_c,  post_edge_c;
  logic [TW-1:0] pre_timer,   post_timer;
  logic          pre_valid,   post_valid;

  logic          pair_ltp_c, pair_ltd_c;
  logic [TW-1:0] dt_c;
  logic [WW-1:0] delta_c;
  logic [WW:0]   sum_c;

  logic [WW-1:0] weight_d;
  logic [TW-1:0] time_diff_d;
  logic          update_w_flag_d, ltp_d, ltd_d;

  // Amplitude halves every 2^TAU_SHIFT cycles of separation; large shifts flush to zero.
  function automatic logic [WW-1:0] decay(input logic [WW-1:0] amp, input logic [TW-1:0] dt);
    logic [TW-1:0] shamt;
    shamt = (dt - TW'(1)) >> TAU_SHIFT;
    if (shamt >= TW'(WW)) begin
      decay = '0;
    end else begin
      decay = amp >> shamt;
    end
  endfunction

  stdp_trace #(.TW(TW), .WINDOW(WINDOW)) u_pre (
    .clk     (clk),
    .rst_n   (rst_n),
    .spike   (pre_spike),
    .consume (pair_ltp_c),
    .edge_c  (pre_edge_c),
    .timer   (pre_timer),
    .valid   (pre_valid)
  );

  stdp_trace #(.TW(TW), .WINDOW(WINDOW)) u_post (
    .clk     (clk),
    .rst_n   (rst_n),
    .spike   (post_spike),
    .consume (pair_ltd_c),
    .edge_c  (post_edge_c),
    .timer   (post_timer),
    .valid   (post_valid)
  );

  // Coincident edges never pair; a lone edge pairs with a still-valid opposite trace.
  always_comb begin
    pair_ltp_c = post_edge_c & ~pre_edge_c & pre_valid;
    pair_ltd_c = pre_edge_c & ~post_edge_c & post_valid;
    dt_c       = pair_ltp_c ? pre_timer : post_timer;
    delta_c    = pair_ltp_c ? decay(A_PLUS_V, dt_c) : decay(A_MINUS_V, dt_c);
    sum_c      = {1'b0, weight} + {1'b0, delta_c};
  end

  always_comb begin
    weight_d        = weight;
    time_diff_d     = time_diff;
    update_w_flag_d = 1'b0;
    ltp_d           = 1'b0;
    ltd_d           = 1'b0;
    if (learn_en && pair_ltp_c) begin
      weight_d        = (sum_c > W_MAX_V9) ? W_MAX_V : sum_c[WW-1:0];
      time_diff_d     = dt_c;
      update_w_flag_d = 1'b1;
      ltp_d           = 1'b1;
    end else if (learn_en && pair_ltd_c) begin
      weight_d        = (delta_c > weight) ? '0 : weight - delta_c;
      time_diff_d     = dt_c;
      update_w_flag_d = 1'b1;
      ltd_d           = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight        <= W_INIT_V;
      time_diff     <= '0;
      update_w_flag <= 1'b0;
      ltp           <= 1'b0;
      ltd           <= 1'b0;
    end else begin
      weight        <= weight_d;
      time_diff     <= time_diff_d;
      update_w_flag <= update_w_flag_d;
      ltp           <= ltp_d;
      ltd           <= ltd_d;
    end
  end

endmodule
